// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and limits for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_t;

    typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;

    localparam int MAX_WAIT = 7;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way winner pick for the memory arbiter
module rr_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
)(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output req_id_t    grant
);

    // Lone requester wins; on a tie either CPU wins outright or the one not granted last wins
    always_comb begin
        grant = REQ_CPU;
        if (req == 2'b10) begin
            grant = REQ_DBG;
        end else if (req == 2'b11 && FIXED_PRIO == 0) begin
            grant = (last_grant == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single-port memory between the CPU and the debug loader
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 0,
    parameter int FIXED_PRIO  = 0
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_write,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    inout  wire  [DATA_W-1:0] mem_data
);

    localparam logic [2:0] WAIT_INIT =
        3'((WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES);

    arb_state_t        state_q;
    arb_state_t        state_d;
    req_id_t           grant_id;
    req_id_t           id_q;
    req_id_t           last_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        wait_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic [1:0]        req_vec;
    logic              final_access;

    assign req_vec      = {dbg_req, cpu_req};
    assign final_access = (state_q == ACCESS) && (wait_q == 3'd0);

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req        (req_vec),
        .last_grant (last_q),
        .grant      (grant_id)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE -> ACCESS on any request, ACCESS -> ACK once the wait count is spent
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_vec) state_d = ACCESS;
            ACCESS:  if (wait_q == 3'd0) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: write strobe only in the last ACCESS cycle, ack to the latched winner in ACK
    always_comb begin
        mem_write = 1'b0;
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        case (state_q)
            ACCESS: mem_write = final_access && write_q;
            ACK: begin
                cpu_ack = (id_q == REQ_CPU);
                dbg_ack = (id_q == REQ_DBG);
            end
            default: ;
        endcase
    end

    // Latch the winning request, run the wait counter, and capture read data at the closing edge
    always_ff @(posedge clock) begin
        if (reset) begin
            id_q        <= REQ_CPU;
            last_q      <= REQ_DBG;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            wait_q      <= 3'd0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (state_q == IDLE && |req_vec) begin
                id_q    <= grant_id;
                last_q  <= grant_id;
                addr_q  <= (grant_id == REQ_DBG) ? dbg_addr  : cpu_addr;
                write_q <= (grant_id == REQ_DBG) ? dbg_write : cpu_write;
                wdata_q <= (grant_id == REQ_DBG) ? dbg_wdata : cpu_wdata;
                wait_q  <= WAIT_INIT;
            end else if (state_q == ACCESS && wait_q != 3'd0) begin
                wait_q <= wait_q - 3'd1;
            end
            if (final_access && !write_q) begin
                if (id_q == REQ_CPU) begin
                    cpu_rdata_q <= mem_data;
                end else begin
                    dbg_rdata_q <= mem_data;
                end
            end
        end
    end

    // The bus is driven only during the write strobe so reads always see a turnaround
    assign mem_data    = mem_write ? wdata_q : 'z;
    assign mem_address = addr_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        cpu_req, cpu_write, dbg_req, dbg_write;
    logic [11:0] cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        mem_oe;
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    logic        cpu_ack0, dbg_ack0, mem_write0;
    logic        cpu_ack1, dbg_ack1, mem_write1;
    logic        cpu_ack2, dbg_ack2, mem_write2;
    logic [15:0] cpu_rdata0, dbg_rdata0, cpu_rdata1, dbg_rdata1, cpu_rdata2, dbg_rdata2;
    logic [11:0] mem_address0, mem_address1, mem_address2;
    wire  [15:0] mem_data0, mem_data1, mem_data2;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.WAIT_STATES(0), .FIXED_PRIO(0)) dut0 (
        .clock(clock), .reset(rst_a),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack0), .cpu_rdata(cpu_rdata0),
        .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack0), .dbg_rdata(dbg_rdata0),
        .mem_address(mem_address0), .mem_write(mem_write0), .mem_data(mem_data0)
    );

    mem_arbiter #(.WAIT_STATES(0), .FIXED_PRIO(1)) dut1 (
        .clock(clock), .reset(rst_a),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
        .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack1), .dbg_rdata(dbg_rdata1),
        .mem_address(mem_address1), .mem_write(mem_write1), .mem_data(mem_data1)
    );

    mem_arbiter #(.WAIT_STATES(2), .FIXED_PRIO(0)) dut2 (
        .clock(clock), .reset(rst_b),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2),
        .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack2), .dbg_rdata(dbg_rdata2),
        .mem_address(mem_address2), .mem_write(mem_write2), .mem_data(mem_data2)
    );

    // Memory models: asynchronous read onto the bus when not writing, write on the clock edge
    assign mem_data0 = (mem_oe && !mem_write0) ? mem0[mem_address0[7:0]] : 'z;
    assign mem_data1 = (mem_oe && !mem_write1) ? mem1[mem_address1[7:0]] : 'z;
    assign mem_data2 = (mem_oe && !mem_write2) ? mem2[mem_address2[7:0]] : 'z;

    always @(posedge clock) begin
        if (pl_en) begin
            mem0[pl_addr] <= pl_data;
            mem1[pl_addr] <= pl_data;
            mem2[pl_addr] <= pl_data;
        end else begin
            if (mem_write0) mem0[mem_address0[7:0]] <= mem_data0;
            if (mem_write1) mem1[mem_address1[7:0]] <= mem_data1;
            if (mem_write2) mem2[mem_address2[7:0]] <= mem_data2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    function automatic logic ack_of(input int inst, input logic dbg);
        case (inst)
            0:       return dbg ? dbg_ack0 : cpu_ack0;
            1:       return dbg ? dbg_ack1 : cpu_ack1;
            default: return dbg ? dbg_ack2 : cpu_ack2;
        endcase
    endfunction

    // One access on the shared request lines; returns latency in cycles (req cycle = 1)
    task automatic access(input int inst, input logic dbg, input logic wr,
                          input logic [11:0] a, input logic [15:0] d,
                          output int lat, output int other_acks);
        @(negedge clock);
        if (dbg) begin
            dbg_req = 1'b1; dbg_write = wr; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
        end
        lat = 1;
        other_acks = 0;
        while (!ack_of(inst, dbg) && lat < 20) begin
            @(negedge clock);
            lat++;
            if (ack_of(inst, !dbg)) other_acks++;
        end
        if (!ack_of(inst, dbg)) lat = 99;
        if (dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
    endtask

    initial begin
        int          lat, oth, bad, mwc, ackc;
        int          c0, d0, c1, d1, dbl;
        logic [3:0]  ord0;
        logic        prev0, any0;

        rst_a = 1'b1; rst_b = 1'b1; mem_oe = 1'b1; pl_en = 1'b0;
        pl_addr = '0; pl_data = '0;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        preload(8'd20, 16'h0000);
        preload(8'd21, 16'h00A5);
        preload(8'd22, 16'h0007);
        preload(8'd23, 16'h00F0);
        preload(8'd30, 16'h5555);

        // Reset state
        @(negedge clock);
        check("rst_cpu_ack",   cpu_ack0,   0);
        check("rst_dbg_ack",   dbg_ack0,   0);
        check("rst_cpu_rdata", cpu_rdata0, 0);
        check("rst_dbg_rdata", dbg_rdata0, 0);
        check("rst_addr0",     mem_address0, 0);
        check("rst_addr1",     mem_address1, 0);
        check("rst_mw0",       mem_write0, 0);
        check("rst_addr2",     mem_address2, 0);
        check("rst_mw2",       mem_write2, 0);
        check("rst_acks2",     {cpu_ack2, dbg_ack2}, 0);
        rst_a = 1'b0;

        // CPU reads 20 then 22
        access(0, 1'b0, 1'b0, 12'd20, 16'h0, lat, oth);
        check("rd20_latency", lat, 3);
        check("rd20_data", cpu_rdata0, 16'h0000);
        check("rd20_no_dbg_ack", oth, 0);
        access(0, 1'b0, 1'b0, 12'd22, 16'h0, lat, oth);
        check("rd22_latency", lat, 3);
        check("rd22_data", cpu_rdata0, 16'h0007);
        check("rd22_data_fp", cpu_rdata1, 16'h0007);
        check("rd22_no_dbg_ack", oth, 0);

        // Loader write 23 = 1234 with the memory output disabled to observe the bus drive
        mem_oe = 1'b0;
        @(negedge clock);
        dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 12'd23; dbg_wdata = 16'h1234;
        check("wr_idle_mw", mem_write0, 0);
        check("wr_idle_bus", (mem_data0 === 16'h1234), 0);
        @(negedge clock);
        check("wr_access_mw", mem_write0, 1);
        check("wr_access_bus", mem_data0, 16'h1234);
        check("wr_access_addr", mem_address0, 12'd23);
        @(negedge clock);
        check("wr_ack", dbg_ack0, 1);
        check("wr_ack_mw", mem_write0, 0);
        check("wr_ack_bus", (mem_data0 === 16'h1234), 0);
        dbg_req = 1'b0;
        @(negedge clock);
        check("wr_after_mw", mem_write0, 0);
        check("wr_after_ack", dbg_ack0, 0);
        check("wr_mem", mem0[23], 16'h1234);
        check("wr_keeps_cpu_rdata", cpu_rdata0, 16'h0007);
        check("wr_keeps_dbg_rdata", dbg_rdata0, 16'h0000);
        mem_oe = 1'b1;
        access(0, 1'b0, 1'b0, 12'd23, 16'h0, lat, oth);
        check("rd23_latency", lat, 3);
        check("rd23_data", cpu_rdata0, 16'h1234);

        // Both requesters held for four accesses, from a fresh pointer
        @(negedge clock); rst_a = 1'b1;
        @(negedge clock); rst_a = 1'b0;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'd21;
        dbg_req = 1'b1; dbg_write = 1'b0; dbg_addr = 12'd22;
        ord0 = '0; c0 = 0; d0 = 0; c1 = 0; d1 = 0; dbl = 0; prev0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clock);
            if (cpu_ack0) begin c0++; ord0 = {ord0[2:0], 1'b0}; end
            if (dbg_ack0) begin d0++; ord0 = {ord0[2:0], 1'b1}; end
            if (cpu_ack1) c1++;
            if (dbg_ack1) d1++;
            any0 = cpu_ack0 || dbg_ack0;
            if (any0 && prev0) dbl++;
            prev0 = any0;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("rr_order", ord0, 4'b0101);
        check("rr_cpu_acks", c0, 2);
        check("rr_dbg_acks", d0, 2);
        check("rr_single_pulse", dbl, 0);
        check("rr_cpu_rdata", cpu_rdata0, 16'h00A5);
        check("rr_dbg_rdata", dbg_rdata0, 16'h0007);
        check("fp_cpu_acks", c1, 4);
        check("fp_dbg_acks", d1, 0);
        check("fp_dbg_rdata", dbg_rdata1, 16'h0000);

        // WAIT_STATES=2: CPU read 22, address held through all ACCESS cycles
        @(negedge clock);
        rst_b = 1'b0;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'd22;
        lat = 1; bad = 0; mwc = 0;
        while (!cpu_ack2 && lat < 20) begin
            @(negedge clock);
            lat++;
            if (lat >= 2 && lat <= 4 && mem_address2 !== 12'd22) bad++;
            if (mem_write2) mwc++;
        end
        if (!cpu_ack2) lat = 99;
        cpu_req = 1'b0;
        check("ws_latency", lat, 5);
        check("ws_addr_stable", bad, 0);
        check("ws_no_write", mwc, 0);
        check("ws_rdata", cpu_rdata2, 16'h0007);

        // Reset in the first ACCESS cycle of a write
        @(negedge clock);
        dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 12'd30; dbg_wdata = 16'hABCD;
        @(negedge clock);
        check("mr_in_access_addr", mem_address2, 12'd30);
        check("mr_in_access_mw", mem_write2, 0);
        rst_b = 1'b1; dbg_req = 1'b0;
        @(negedge clock);
        rst_b = 1'b0;
        mwc = 0; ackc = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_write2) mwc++;
            if (dbg_ack2 || cpu_ack2) ackc++;
            @(negedge clock);
        end
        check("mr_no_write", mwc, 0);
        check("mr_no_ack", ackc, 0);
        check("mr_mem_kept", mem2[30], 16'h5555);
        access(2, 1'b1, 1'b0, 12'd30, 16'h0, lat, oth);
        check("mr_next_latency", lat, 5);
        check("mr_next_rdata", dbg_rdata2, 16'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
